// File: rtl/dvid_tmds_encoder_n_if.sv
// Pixel-side bus of the DVI-D TMDS encoder: timing, pixel data and encoded symbols.
// The timing/pixel source uses the master modport, the encoder uses the slave modport.
interface dvid_tmds_encoder_n_if #(
   parameter int CHANNELS = 3,
   parameter int IN_W     = 3
);
   logic                       blank;
   logic                       hsync;
   logic                       vsync;
   logic [2*CHANNELS-1:0]      ctl;
   logic [CHANNELS*IN_W-1:0]   pix;
   logic [CHANNELS*10-1:0]     symbols;

   modport master (
      output blank, hsync, vsync, ctl, pix,
      input  symbols
   );

   modport slave (
      input  blank, hsync, vsync, ctl, pix,
      output symbols
   );
endinterface

// File: rtl/dvid_tmds_encoder_n.sv
// Two-stage TMDS encoder with per-channel running disparity and control-code insertion.
// Optional macro DVID_DISPARITY_MON_EN adds disp/disp_err disparity monitor outputs.
module dvid_tmds_encoder_n #(
   parameter int CHANNELS = 3,
   parameter int IN_W     = 3,
   parameter int CTL_CH   = 0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   dvid_tmds_encoder_n_if.slave  bus
`ifdef DVID_DISPARITY_MON_EN
   ,
   output logic [CHANNELS*5-1:0] disp,
   output logic                  disp_err
`endif
);

   localparam logic [9:0] CTRL_00 = 10'b1101010100;
   localparam logic [9:0] CTRL_01 = 10'b0010101011;
   localparam logic [9:0] CTRL_10 = 10'b0101010100;
   localparam logic [9:0] CTRL_11 = 10'b1010101011;

   // Fill 8 bits MSB-first by repeating the input word
   function automatic logic [7:0] widen(input logic [IN_W-1:0] p);
      logic [7:0] w;
      for (int i = 0; i < 8; i++) w[7-i] = p[IN_W-1-(i%IN_W)];
      return w;
   endfunction

   function automatic logic [3:0] ones8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
      return n;
   endfunction

   function automatic logic [8:0] qm_encode(input logic [7:0] d);
      logic [8:0] q;
      logic [3:0] n1;
      logic       use_xnor;
      n1       = ones8(d);
      use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
      q[0]     = d[0];
      for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
      q[8]     = ~use_xnor;
      return q;
   endfunction

   // ones minus zeros of a data byte, i.e. 2*n1 - 8
   function automatic logic signed [6:0] balance(input logic [7:0] v);
      return $signed({2'b00, ones8(v), 1'b0}) - 7'sd8;
   endfunction

   function automatic logic [9:0] ctl_code(input logic [1:0] c);
      logic [9:0] s;
      case (c)
         2'b00:   s = CTRL_00;
         2'b01:   s = CTRL_01;
         2'b10:   s = CTRL_10;
         default: s = CTRL_11;
      endcase
      return s;
   endfunction

   logic                     de_p1;
   logic [CHANNELS*10-1:0]   sym_all;
`ifdef DVID_DISPARITY_MON_EN
   logic [CHANNELS-1:0]      over;
`endif

   // ---- stage 1: DE capture (shared by all channels) ----
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) de_p1 <= 1'b0;
      else          de_p1 <= ~bus.blank;
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [7:0]        d;
      logic [1:0]        ctl_in;
      logic [8:0]        qm_p1;
      logic [1:0]        ctl_p1;
      logic signed [4:0] cnt_p2;
      logic [9:0]        sym_p2;
      logic signed [6:0] cnt_cur;
      logic signed [6:0] bal;
      logic signed [6:0] cnt_nxt;
      logic [9:0]        sym_nxt;

      assign d = widen(bus.pix[c*IN_W +: IN_W]);

      if (c == CTL_CH) begin : g_sync
         logic unused_ctl;
         assign ctl_in     = {bus.vsync, bus.hsync};
         assign unused_ctl = ^bus.ctl[2*c +: 2];
      end else begin : g_ext
         assign ctl_in = bus.ctl[2*c +: 2];
      end

      // ---- stage 1: transition-minimised word and control bits ----
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) ctl_p1 <= 2'b00;
         else          ctl_p1 <= ctl_in;
      end

      always_ff @(posedge clk) begin
         qm_p1 <= qm_encode(d);
      end

      // ---- stage 2: DC balancing or control-code selection ----
      always_comb begin
         cnt_cur = {{2{cnt_p2[4]}}, cnt_p2};
         bal     = balance(qm_p1[7:0]);
         sym_nxt = ctl_code(ctl_p1);
         cnt_nxt = 7'sd0;
         if (de_p1) begin
            if ((cnt_cur == 7'sd0) || (bal == 7'sd0)) begin
               if (qm_p1[8]) begin
                  sym_nxt = {2'b01, qm_p1[7:0]};
                  cnt_nxt = cnt_cur + bal;
               end else begin
                  sym_nxt = {2'b10, ~qm_p1[7:0]};
                  cnt_nxt = cnt_cur - bal;
               end
            end else if (((cnt_cur > 7'sd0) && (bal > 7'sd0)) ||
                         ((cnt_cur < 7'sd0) && (bal < 7'sd0))) begin
               sym_nxt = {1'b1, qm_p1[8], ~qm_p1[7:0]};
               cnt_nxt = cnt_cur - bal + (qm_p1[8] ? 7'sd2 : 7'sd0);
            end else begin
               sym_nxt = {1'b0, qm_p1[8], qm_p1[7:0]};
               cnt_nxt = cnt_cur + bal - (qm_p1[8] ? 7'sd0 : 7'sd2);
            end
         end
      end

      // Symbols reset too: the link must show a control code while held in reset
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            sym_p2 <= CTRL_00;
            cnt_p2 <= 5'sd0;
         end else begin
            sym_p2 <= sym_nxt;
            cnt_p2 <= cnt_nxt[4:0];
         end
      end

      assign sym_all[c*10 +: 10] = sym_p2;

`ifdef DVID_DISPARITY_MON_EN
      assign over[c]           = de_p1 && ((cnt_nxt > 7'sd10) || (cnt_nxt < -7'sd10));
      assign disp[c*5 +: 5]    = cnt_p2;
`else
      logic unused_hi;
      assign unused_hi = ^cnt_nxt[6:5];
`endif
   end

   assign bus.symbols = sym_all;

`ifdef DVID_DISPARITY_MON_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)   disp_err <= 1'b0;
      else if (|over) disp_err <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_dvid_tmds_encoder_n.sv
// Scoreboard bench for dvid_tmds_encoder_n (3 channels, 3-bit colour, CTL_CH=0).
// Driver queues expected symbols with their due cycle; a negedge monitor pops and compares.
module tb_dvid_tmds_encoder_n;
   localparam int CH = 3;
   localparam int IW = 3;
   localparam logic [9:0] C00 = 10'b1101010100;
   localparam logic [9:0] C01 = 10'b0010101011;
   localparam logic [9:0] C10 = 10'b0101010100;
   localparam logic [9:0] C11 = 10'b1010101011;
   localparam logic [9:0] Z0  = 10'b0100000000;
   localparam logic [9:0] Z1  = 10'b1111111111;
   localparam logic [9:0] B6  = 10'b1011000111;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   dvid_tmds_encoder_n_if #(.CHANNELS(CH), .IN_W(IW)) bus ();

`ifdef DVID_DISPARITY_MON_EN
   logic [CH*5-1:0] disp;
   logic            disp_err;
`endif

   dvid_tmds_encoder_n #(.CHANNELS(CH), .IN_W(IW), .CTL_CH(0)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
`ifdef DVID_DISPARITY_MON_EN
      ,
      .disp     (disp),
      .disp_err (disp_err)
`endif
   );

   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   int n_chk = 0;
   int n_err = 0;
   int vec_id = 0;
   int cnt_m [CH];

   int          q_due  [$];
   logic [29:0] q_sym  [$];
   int          q_id   [$];
`ifdef DVID_DISPARITY_MON_EN
   logic [14:0] q_disp [$];
`endif

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   // Reference encoder written from the DVI algorithm using integer counts
   function automatic logic [9:0] model_enc(input logic [7:0] d, input bit de,
                                            input logic [1:0] c, inout int cnt);
      int n1, nq;
      bit xn, q8;
      logic [7:0] q;
      logic [9:0] o;
      if (!de) begin
         cnt = 0;
         case (c)
            2'b00:   o = C00;
            2'b01:   o = C01;
            2'b10:   o = C10;
            default: o = C11;
         endcase
         return o;
      end
      n1 = $countones(d);
      xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
      q[0] = d[0];
      for (int i = 1; i < 8; i++) q[i] = xn ? (q[i-1] == d[i]) : (q[i-1] != d[i]);
      q8 = !xn;
      nq = $countones(q);
      if (cnt == 0 || nq == 4) begin
         if (q8) begin o = {2'b01, q};  cnt += 2*nq - 8; end
         else    begin o = {2'b10, ~q}; cnt += 8 - 2*nq; end
      end else if ((cnt > 0 && nq > 4) || (cnt < 0 && nq < 4)) begin
         o = {1'b1, q8, ~q};
         cnt += (q8 ? 2 : 0) + 8 - 2*nq;
      end else begin
         o = {1'b0, q8, q};
         cnt += 2*nq - 8 - (q8 ? 0 : 2);
      end
      return o;
   endfunction

   task automatic push_exp(input int due, input logic [29:0] s);
      logic [14:0] dp;
      for (int ch = 0; ch < CH; ch++) dp[ch*5 +: 5] = 5'(cnt_m[ch]);
      q_due.push_back(due);
      q_sym.push_back(s);
      q_id.push_back(vec_id);
`ifdef DVID_DISPARITY_MON_EN
      q_disp.push_back(dp);
`else
      if (dp == 15'h7fff) q_id[q_id.size()-1] = vec_id;
`endif
   endtask

   // Apply one cycle of inputs; symbol due two rising edges later
   task automatic drive(input bit blk, input bit hs, input bit vs, input logic [5:0] c,
                        input logic [8:0] p, input bit has_hand, input logic [29:0] hand);
      logic [29:0] e;
      logic [2:0]  pc;
      logic [1:0]  cc;
      bus.blank = blk;
      bus.hsync = hs;
      bus.vsync = vs;
      bus.ctl   = c;
      bus.pix   = p;
      for (int ch = 0; ch < CH; ch++) begin
         pc = p[ch*3 +: 3];
         cc = (ch == 0) ? {vs, hs} : c[ch*2 +: 2];
         e[ch*10 +: 10] = model_enc({pc, pc, pc[2:1]}, !blk, cc, cnt_m[ch]);
      end
      push_exp(edge_cnt + 2, has_hand ? hand : e);
      @(posedge clk);
      #1;
   endtask

   task automatic flush_model();
      q_due.delete();
      q_sym.delete();
      q_id.delete();
`ifdef DVID_DISPARITY_MON_EN
      q_disp.delete();
`endif
      for (int ch = 0; ch < CH; ch++) cnt_m[ch] = 0;
   endtask

   always @(negedge clk) begin
      int          due, id;
      logic [29:0] es;
      while (q_due.size() > 0 && q_due[0] <= edge_cnt) begin
         due = q_due.pop_front();
         es  = q_sym.pop_front();
         id  = q_id.pop_front();
         chk($sformatf("sym vec%0d due%0d", id, due), 32'(bus.symbols), 32'(es));
`ifdef DVID_DISPARITY_MON_EN
         chk($sformatf("disp vec%0d", id), 32'(disp), 32'(q_disp.pop_front()));
         chk($sformatf("disp_err vec%0d", id), 32'(disp_err), 32'd0);
`endif
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL timeout: simulation bound reached, errors=%0d", n_err);
      $fatal(1);
   end

   initial begin
      bit blk;
      int run;
      int guard;
      bus.blank = 1'b1;
      bus.hsync = 1'b0;
      bus.vsync = 1'b0;
      bus.ctl   = '0;
      bus.pix   = '0;
      for (int ch = 0; ch < CH; ch++) cnt_m[ch] = 0;

      repeat (3) begin
         @(posedge clk);
         #1;
         chk("reset_hold", 32'(bus.symbols), 32'({C00, C00, C00}));
      end
      reset_n = 1'b1;
      push_exp(edge_cnt + 1, {C00, C00, C00});

      vec_id = 1;
      repeat (4) drive(1, 0, 0, 6'b0, 9'b0, 1, {C00, C00, C00});
      vec_id = 2; drive(1, 1, 0, 6'b0, 9'b0, 1, {C00, C00, C01});
      vec_id = 3; drive(1, 0, 1, 6'b0, 9'b0, 1, {C00, C00, C10});
      vec_id = 4; drive(1, 1, 1, 6'b0, 9'b0, 1, {C00, C00, C11});
      vec_id = 5; drive(1, 0, 0, 6'b10_01_11, 9'b0, 1, {C10, C01, C00});

      vec_id = 6;
      drive(0, 0, 0, 6'b0, 9'b0, 1, {Z0, Z0, Z0});
      drive(0, 0, 0, 6'b0, 9'b0, 1, {Z1, Z1, Z1});
      drive(0, 0, 0, 6'b0, 9'b0, 1, {Z0, Z0, Z0});

      vec_id = 7;
      drive(1, 0, 0, 6'b0, 9'b0, 1, {C00, C00, C00});
      drive(0, 0, 0, 6'b0, {3'b000, 3'b000, 3'b101}, 1, {Z0, Z0, B6});
      vec_id = 8;
      drive(1, 0, 0, 6'b0, 9'b0, 1, {C00, C00, C00});

      vec_id = 9;
      repeat (6) drive(0, 0, 0, 6'b0, 9'($urandom), 0, '0);
      reset_n = 1'b0;
      #1;
      chk("async_reset", 32'(bus.symbols), 32'({C00, C00, C00}));
      flush_model();
      @(posedge clk);
      #1;
      chk("reset_midline", 32'(bus.symbols), 32'({C00, C00, C00}));
      reset_n = 1'b1;
      push_exp(edge_cnt + 1, {C00, C00, C00});
      vec_id = 10;
      drive(0, 0, 0, 6'b0, {3'b000, 3'b000, 3'b101}, 1, {Z0, Z0, B6});

      vec_id = 11;
      blk = 1'b0;
      run = 0;
      for (int i = 0; i < 10000; i++) begin
         if (run == 0) begin
            blk = !blk;
            run = $urandom_range(1, 24);
         end
         run--;
         drive(blk, 1'($urandom), 1'($urandom), 6'($urandom), 9'($urandom), 0, '0);
      end

      guard = 0;
      while (q_due.size() > 0 && guard < 20) begin
         @(posedge clk);
         guard++;
      end
      @(negedge clk);
      #1;
      chk("drain", 32'(q_due.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/dvid_tmds_encoder_n.md
Name: dvid_tmds_encoder_n

Overview:
Parametrised TMDS encoder for the DVI-D output path. It encodes CHANNELS colour channels per pixel clock into 10-bit TMDS symbols, with per-channel running-disparity DC balancing and per-channel control-code insertion during blanking. It sits between the VGA timing/pixel source and the 10:1 serialiser (clkx5 DDR shift register), and generalises the fixed 3-channel, 3-bit encoder.

Parameters:
CHANNELS, 3, number of TMDS data channels encoded in parallel (1..4)
IN_W, 3, colour bits per channel on input (1..8); widened to 8 bits by MSB replication
CTL_CH, 0, index of the channel that carries {vsync,hsync} as its control bits

Ports:
clk  in  1  pixel clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
blank  in  1  1 = blanking interval (control period), 0 = active video (DE = ~blank)
hsync  in  1  horizontal sync, routed to CTL_CH ctl bit 0
vsync  in  1  vertical sync, routed to CTL_CH ctl bit 1
ctl  in  2*CHANNELS  extra control bits {c1,c0} per channel; ignored for CTL_CH
pix  in  CHANNELS*IN_W  packed pixel data, channel 0 in LSBs
symbols  out  CHANNELS*10  packed TMDS symbols, channel 0 in LSBs, bit 0 transmitted first

Behaviour:
- Reset (reset_n=0, async assert, sync release): every channel symbol = 10'b1101010100 (ctl 00), disparity counters = 0, stage-1 DE = 0.
- Latency: fixed 2 clk from inputs to symbols. Stage 1 registers q_m, DE, ctl; stage 2 registers symbol and updates cnt.
- Widening: D = first 8 bits of {pix_ch, pix_ch, ...}, MSB-aligned. Example: IN_W=3, 3'b101 -> 8'b10110110. IN_W=8 passes through unchanged.
- Stage 1: n1 = popcount(D).
  - If n1>4, or n1==4 and D[0]==0: XNOR chain, q_m[8]=0.
  - Otherwise: XOR chain, q_m[8]=1.
  - In both cases q_m[0]=D[0].
- Stage 2, DE=1: n1q/n0q = ones/zeros of q_m[7:0]; cnt is a signed 5-bit value per channel.
  - cnt==0 or n1q==n0q:
    - out = {~q_m8, q_m8, q_m8 ? q_m[7:0] : ~q_m[7:0]}
    - cnt += q_m8 ? n1q-n0q : n0q-n1q
  - (cnt>0 and n1q>n0q) or (cnt<0 and n0q>n1q):
    - out = {1, q_m8, ~q_m[7:0]}
    - cnt += 2*q_m8 + n0q-n1q
  - Otherwise:
    - out = {0, q_m8, q_m[7:0]}
    - cnt += n1q-n0q - 2*~q_m8
- Stage 2, DE=0: cnt is forced to 0. Output is the control code selected by {c1,c0}:
  - 00 -> 1101010100
  - 01 -> 0010101011
  - 10 -> 0101010100
  - 11 -> 1010101011
- cnt stays even and within -10..+10 for any input sequence. Arithmetic uses at least 5-bit signed width, with no wrap.
- DE edges:
  - The first active pixel after blanking encodes with cnt=0.
  - The first blank cycle after active outputs a control code regardless of cnt.
  - There is no pixel/control mixing within one symbol.
- Reset mid-line: outputs return to the ctl-00 code immediately. After release, the first two symbols are ctl-00 codes (flushed pipeline) until new inputs propagate.
- Channels are fully independent; each has its own cnt.

Optional Feature:
DVID_DISPARITY_MON_EN.
- Defined:
  - Adds output disp (CHANNELS*5, signed 2's complement per channel), the registered cnt after each update.
  - Adds output disp_err (1), sticky, set if any |cnt| > 10 is ever computed; cleared only by reset_n.
- Undefined: neither port exists and no extra logic is built.

Test Plan:
- Reset held, then released with blank=1, hsync=vsync=0 -> all channel symbols = 1101010100 during reset and for every cycle after release.
- blank=1, hsync=1, vsync=0 -> CTL_CH symbol = 0010101011 exactly 2 clk later; other channels stay 1101010100 (ctl=0).
- IN_W=8, CHANNELS=1, blank=0, pix=0x00 for 3 cycles -> symbols 0100000000, 1111111111, 0100000000; cnt -8, +2, -6.
- IN_W=3, pix ch0=3'b101 for one active pixel after blanking -> D=0xB6. Bench compares against a reference-model encode with cnt=0.
- Random 10k pixels with random blank runs, CHANNELS=3 -> symbols match the bench model bit-exact. With DVID_DISPARITY_MON_EN: disp matches model cnt, disp_err stays 0.
- reset_n pulsed low mid-active-line -> symbols go to 1101010100 asynchronously. cnt=0 on resume: first active symbol matches a cnt=0 encode.
